// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drain stage between the synchronous byte FIFO and the serial pad. Pops one
//   byte at a time through the FIFO rd/empty/data_out handshake and sends it as
//   an async frame: start(0), 8 data bits LSB first, optional even parity,
//   then 1 or 2 stop(1) bits.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   PARITY_EN     1 = insert even-parity bit after the data bits
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         asynchronous, active-high reset
//   en          1 = allowed to start new frames
//   fifo_empty  FIFO empty flag (only looked at in IDLE)
//   fifo_data   FIFO data_out, valid the cycle after fifo_rd is sampled
//   fifo_rd     one-cycle pop request per byte
//   tx          serial line, idle high, driven from a flop
//   busy        high whenever the FSM is not in IDLE
//   tx_done     one-cycle pulse in the first IDLE cycle after a frame
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bitEnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    data_d   = data_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    tx_d     = 1'b1;
    bitEnd   = (baud_q == BAUD_MAX);

    // The baud counter only runs while a symbol is on the line and wraps at
    // every bit boundary, so it is back at zero whenever the FSM re-enters IDLE.
    case (state_q)
      START, DATA, PARITY, STOP: baud_d = bitEnd ? '0 : baud_q + 1'b1;
      default: ;
    endcase

    // bit_q doubles as the data bit index in DATA and the stop bit index in STOP.
    case (state_q)
      IDLE: begin
        if (en && !fifo_empty) state_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        data_d   = fifo_data;
        parity_d = ^fifo_data;
        baud_d   = '0;
        bit_d    = '0;
        state_d  = START;
      end
      START: begin
        if (bitEnd) state_d = DATA;
      end
      DATA: begin
        if (bitEnd) begin
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bitEnd) state_d = STOP;
      end
      STOP: begin
        if (bitEnd) begin
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered: its next value is chosen from the state being entered,
    // so the line level lines up exactly with the registered state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign fifo_rd = (state_q == FETCH);
  assign busy    = (state_q != IDLE);
  assign tx      = tx_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Two instances share clock, reset, enable and the pushed byte stream:
//   index 0 is 4 clk/bit, no parity, 1 stop; index 1 is 4 clk/bit, even
//   parity, 2 stops. Each has its own FIFO model with registered data_out.
//   A frame-level reference model predicts every output on every cycle.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int LEN0 = (9 + 0 + 1) * CPB;
  localparam int LEN1 = (9 + 1 + 2) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] fifoEmpty = 2'b11;
  logic [7:0] fdata0 = 8'h00;
  logic [7:0] fdata1 = 8'h00;
  logic [1:0] rdV, txV, busyV, doneV;

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic [7:0] popTmp;

  int compared = 0;
  int mismatched = 0;

  int         mPos[2];
  logic       mDone[2];
  logic [7:0] mByte[2];
  int         mLen[2];
  int         mPar[2];
  logic [1:0] rdSeen = 2'b00;

  int   rdCnt[2];
  int   doneCnt[2];
  int   busyCnt[2];
  logic txHist[64];
  int   busyIdx = 0;
  int   gapCnt = 0;
  int   lastGap = -1;
  bit   gapRun = 1'b0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dutA (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifoEmpty[0]), .fifo_data(fdata0),
    .fifo_rd(rdV[0]), .tx(txV[0]), .busy(busyV[0]), .tx_done(doneV[0])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dutB (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifoEmpty[1]), .fifo_data(fdata1),
    .fifo_rd(rdV[1]), .tx(txV[1]), .busy(busyV[1]), .tx_done(doneV[1])
  );

  always #5 clk = ~clk;

  // Line level of symbol 'sym' within a frame: 0 start, 1..8 data LSB first,
  // 9 parity when enabled, everything after that is stop (high).
  function automatic logic frameBit(input logic [7:0] b, input int parEn, input int sym);
    if (sym == 0) return 1'b0;
    if (sym <= 8) return b[sym-1];
    if (parEn != 0 && sym == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input int k, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s[%0d] at %0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fq0.push_back(b);
    fq1.push_back(b);
  endtask

  task automatic clearCounters();
    for (int k = 0; k < 2; k++) begin
      rdCnt[k] = 0;
      doneCnt[k] = 0;
      busyCnt[k] = 0;
    end
    busyIdx = 0;
    lastGap = -1;
    gapRun = 1'b0;
  endtask

  // Runs until both transmitters are idle with nothing left they may start.
  task automatic waitIdle(input int maxCycles);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (!ok && n < maxCycles) begin
      tick();
      n++;
      if (mPos[0] == 0 && mPos[1] == 0 && (!en || (fq0.size() == 0 && fq1.size() == 0)))
        ok = 1'b1;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL waitIdle: still busy after %0d cycles, required idle", maxCycles);
    end
    tick();
    tick();
  endtask

  task automatic waitPos(input int pos, input int maxCycles);
    int n;
    n = 0;
    while (mPos[0] != pos && n < maxCycles) begin
      tick();
      n++;
    end
    if (mPos[0] != pos) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL waitPos: position %0d, required %0d", mPos[0], pos);
    end
  endtask

  // Reference model plus FIFO models. The model counts cycles since the
  // accepting IDLE edge: 1 = FETCH, 2 = LOAD, 3.. = frame cycles. The FIFO
  // pops on the fifo_rd level seen mid-cycle, so it never races the DUT edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mPos[k] = 0;
        mDone[k] = 1'b0;
      end else begin
        mDone[k] = 1'b0;
        if (mPos[k] == 0) begin
          if (en && ((k == 0) ? fq0.size() : fq1.size()) > 0) begin
            mPos[k] = 1;
            mByte[k] = (k == 0) ? fq0[0] : fq1[0];
          end
        end else if (mPos[k] == 2 + mLen[k]) begin
          mPos[k] = 0;
          mDone[k] = 1'b1;
        end else begin
          mPos[k] = mPos[k] + 1;
        end
      end
    end
    if (rdSeen[0] && fq0.size() > 0) begin
      popTmp = fq0.pop_front();
      fdata0 <= popTmp;
    end
    if (rdSeen[1] && fq1.size() > 0) begin
      popTmp = fq1.pop_front();
      fdata1 <= popTmp;
    end
  end

  // Compare every output of both instances every cycle, mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic eRd, eBusy, eTx, eDone;
      eRd   = !rst && mPos[k] == 1;
      eBusy = !rst && mPos[k] != 0;
      eDone = !rst && mDone[k];
      eTx   = 1'b1;
      if (!rst && mPos[k] >= 3) eTx = frameBit(mByte[k], mPar[k], (mPos[k] - 3) / CPB);
      checkOutput("fifo_rd", k, int'(rdV[k]), int'(eRd));
      checkOutput("busy", k, int'(busyV[k]), int'(eBusy));
      checkOutput("tx", k, int'(txV[k]), int'(eTx));
      checkOutput("tx_done", k, int'(doneV[k]), int'(eDone));
      rdCnt[k] += int'(rdV[k]);
      doneCnt[k] += int'(doneV[k]);
      busyCnt[k] += int'(busyV[k]);
      rdSeen[k] = rdV[k];
    end
    if (busyV[0]) begin
      if (busyIdx < 64) txHist[busyIdx] = txV[0];
      busyIdx++;
    end
    // Line-high gap: from the tx_done cycle up to (excluding) the next start.
    if (gapRun && !txV[0]) begin
      lastGap = gapCnt;
      gapRun = 1'b0;
    end else if (gapRun) begin
      gapCnt++;
    end
    if (doneV[0]) begin
      gapRun = 1'b1;
      gapCnt = 1;
    end
    fifoEmpty[0] = (fq0.size() == 0);
    fifoEmpty[1] = (fq1.size() == 0);
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [9:0] aaSeq;
    aaSeq = 10'b1101010100;
    mLen[0] = LEN0;
    mLen[1] = LEN1;
    mPar[0] = 0;
    mPar[1] = 1;
    mPos[0] = 0;
    mPos[1] = 0;
    mDone[0] = 1'b0;
    mDone[1] = 1'b0;
    mByte[0] = 8'h00;
    mByte[1] = 8'h00;
    clearCounters();

    // Pin the model against hand-derived frames.
    for (int s = 0; s < 10; s++)
      checkOutput("model AA symbol", s, int'(frameBit(8'hAA, 0, s)), int'(aaSeq[s]));
    checkOutput("model 07 parity", 1, int'(frameBit(8'h07, 1, 9)), 1);
    checkOutput("model 55 bit0", 0, int'(frameBit(8'h55, 0, 1)), 1);

    // Idle after reset with an empty FIFO.
    tick();
    tick();
    rst = 1'b0;
    en = 1'b1;
    clearCounters();
    repeat (100) tick();
    checkOutput("idle rd pulses", 0, rdCnt[0], 0);
    checkOutput("idle busy cycles", 0, busyCnt[0], 0);
    checkOutput("idle done pulses", 0, doneCnt[0], 0);

    // Single byte.
    clearCounters();
    applyStimulus(8'hAA);
    waitIdle(500);
    checkOutput("single rd pulses", 0, rdCnt[0], 1);
    checkOutput("single done pulses", 0, doneCnt[0], 1);
    checkOutput("single busy cycles", 0, busyCnt[0], 2 + 40);
    for (int s = 0; s < 10; s++)
      checkOutput("single tx symbol", s, int'(txHist[2 + CPB * s + 1]), int'(aaSeq[s]));

    // Back-to-back frames.
    clearCounters();
    applyStimulus(8'hAA);
    applyStimulus(8'h55);
    waitIdle(500);
    checkOutput("b2b rd pulses", 0, rdCnt[0], 2);
    checkOutput("b2b gap", 0, lastGap, 3);
    checkOutput("b2b done pulses", 1, doneCnt[1], 2);

    // Parity and two stop bits on instance 1.
    clearCounters();
    applyStimulus(8'h07);
    waitIdle(500);
    checkOutput("parity busy cycles", 1, busyCnt[1], 2 + 48);
    checkOutput("plain busy cycles", 0, busyCnt[0], 2 + 40);

    // Enable dropped during the first frame's data bits.
    clearCounters();
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    waitPos(3 + 2 * CPB, 50);
    en = 1'b0;
    waitIdle(500);
    repeat (20) tick();
    checkOutput("en drop rd pulses", 0, rdCnt[0], 1);
    checkOutput("en drop fifo left", 0, fq0.size(), 2);
    checkOutput("en drop fifo left", 1, fq1.size(), 2);
    en = 1'b1;
    waitIdle(1000);
    checkOutput("en resume rd pulses", 1, rdCnt[1], 3);
    checkOutput("en resume done pulses", 0, doneCnt[0], 3);
    checkOutput("en resume fifo left", 0, fq0.size(), 0);

    // Reset in the middle of data bit 3.
    clearCounters();
    applyStimulus(8'hF0);
    waitPos(3 + 4 * CPB + 1, 50);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    checkOutput("reset done pulses", 0, doneCnt[0], 0);
    checkOutput("reset done pulses", 1, doneCnt[1], 0);
    applyStimulus(8'h3C);
    waitIdle(500);
    checkOutput("after reset done pulses", 0, doneCnt[0], 1);
    checkOutput("after reset rd pulses", 0, rdCnt[0], 2);

    // Randomized traffic with enable toggling; the per-cycle compare checks it.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) applyStimulus(8'($urandom_range(0, 255)));
      en = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 80)) tick();
    end
    en = 1'b1;
    waitIdle(8000);
    checkOutput("random fifo drained", 0, fq0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
